// File: rtl/ascon_aead128_axi_master_if.sv
// AXI4-Lite channel bundle between the command-driven initiator and the
// ascon_aead128_ip register slave.
interface ascon_aead128_axi_master_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ascon_aead128_axi_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one
// AXI read or write out, one response (data + resp code) back.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered, each completes independently
// WR_RESP | both write channels done, bready high waiting for B
// RD_REQ  | arvalid held until arready
// RD_RESP | rready high waiting for R
// RESPOND | result presented on rsp_*, held until rsp_ready
module ascon_aead128_axi_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      ack,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    ascon_aead128_axi_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RESPOND = 3'd5
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_done_nxt;
    logic   w_done_nxt;

    // Channel completion including a handshake happening on this edge.
    always_comb begin
        aw_done_nxt = aw_done | (axi.awvalid & axi.awready);
        w_done_nxt  = w_done  | (axi.wvalid & axi.wready);
    end

    // Transaction sequencer; every output is a register of this block.
    always_ff @(posedge ack or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.rready  <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            axi.awaddr  <= cmd_addr;
                            axi.wdata   <= cmd_wdata;
                            axi.wstrb   <= cmd_wstrb;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= WR_REQ;
                        end else begin
                            axi.araddr  <= cmd_addr;
                            axi.arvalid <= 1'b1;
                            state       <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wvalid && axi.wready)   axi.wvalid  <= 1'b0;
                    aw_done <= aw_done_nxt;
                    w_done  <= w_done_nxt;
                    if (aw_done_nxt && w_done_nxt) begin
                        axi.bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid && axi.bready) begin
                        rsp_resp   <= axi.bresp;
                        rsp_rdata  <= '0;
                        axi.bready <= 1'b0;
                        state      <= RESPOND;
                    end
                end
                RD_REQ: begin
                    if (axi.arvalid && axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi.rvalid && axi.rready) begin
                        rsp_rdata  <= axi.rdata;
                        rsp_resp   <= axi.rresp;
                        axi.rready <= 1'b0;
                        state      <= RESPOND;
                    end
                end
                RESPOND: begin
                    // rsp_valid rises one cycle after entry so results are stable first.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_aead128_axi_master.sv
// Bench for ascon_aead128_axi_master: a cycle-stepped slave with
// programmable delays, a word-memory reference model and per-cycle
// protocol expectations.
module tb_ascon_aead128_axi_master;

    logic        ack;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    ascon_aead128_axi_master_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) axi ();

    ascon_aead128_axi_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ack       (ack),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    initial ack = 1'b0;
    always #5 ack = ~ack;

    function automatic logic [140:0] dut_outs();
        return {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, axi.awvalid, axi.awaddr,
                axi.wvalid, axi.wdata, axi.wstrb, axi.bready, axi.arvalid, axi.araddr, axi.rready};
    endfunction

    task automatic slave_idle();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
    endtask

    // One command end to end; the bench plays both command source and slave.
    task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int aw_dly, input int w_dly, input int ar_dly,
                           input int resp_dly, input int rsp_dly, input logic [1:0] code,
                           input bit early, input int exp_lat, input bit abort);
        logic [31:0] exp_data;
        logic [31:0] s_awaddr, s_wdata;
        logic [3:0]  s_wstrb;
        int idx, r_idx, cyc, acc_cyc, rdone_cyc;
        int aw_cnt, w_cnt, ar_cnt, resp_cnt, rsp_cnt;
        bit accepted, aw_done, w_done, ar_done, b_done, r_done, rsp_seen, done, exp_rv;
        bit hs_cmd, hs_aw, hs_w, hs_ar, hs_b, hs_r, hs_rsp, exp_v;
        logic p_awvalid, p_wvalid, p_arvalid;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0] p_wstrb;

        idx = int'(addr[5:2]);
        r_idx = 0; cyc = 0; acc_cyc = 0; rdone_cyc = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; resp_cnt = 0; rsp_cnt = 0;
        accepted = 0; aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
        rsp_seen = 0; done = 0;
        s_awaddr = 0; s_wdata = 0; s_wstrb = 0;

        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            exp_data = 32'h0;
        end else begin
            exp_data = ref_mem[idx];
        end

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;

        while (!done && cyc < 400) begin
            hs_cmd = !accepted && cmd_valid && cmd_ready;
            hs_aw  = axi.awvalid && axi.awready;
            hs_w   = axi.wvalid && axi.wready;
            hs_ar  = axi.arvalid && axi.arready;
            hs_b   = axi.bvalid && axi.bready;
            hs_r   = axi.rvalid && axi.rready;
            hs_rsp = rsp_valid && rsp_ready;
            if (hs_aw) begin
                n_checks++;
                if (axi.awaddr !== addr) begin
                    n_fail++; $display("FAIL %s awaddr: got %h want %h", tag, axi.awaddr, addr);
                end
                s_awaddr = axi.awaddr;
            end
            if (hs_w) begin
                n_checks++;
                if (axi.wdata !== wd || axi.wstrb !== ws) begin
                    n_fail++; $display("FAIL %s wdata/wstrb: got %h/%h want %h/%h", tag, axi.wdata, axi.wstrb, wd, ws);
                end
                s_wdata = axi.wdata; s_wstrb = axi.wstrb;
            end
            if (hs_ar) begin
                n_checks++;
                if (axi.araddr !== addr) begin
                    n_fail++; $display("FAIL %s araddr: got %h want %h", tag, axi.araddr, addr);
                end
            end
            p_awvalid = axi.awvalid; p_wvalid = axi.wvalid; p_arvalid = axi.arvalid;
            p_awaddr = axi.awaddr; p_wdata = axi.wdata; p_wstrb = axi.wstrb; p_araddr = axi.araddr;

            @(negedge ack);
            cyc++;

            if (hs_cmd) begin accepted = 1; acc_cyc = cyc; end
            if ((hs_aw || hs_w) && (aw_done || hs_aw) && (w_done || hs_w)) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) slv_mem[int'(s_awaddr[5:2])][8*b +: 8] = s_wdata[8*b +: 8];
            end
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            if (hs_ar) ar_done = 1;
            if (hs_b || hs_r) rdone_cyc = cyc;
            if (hs_b)  b_done = 1;
            if (hs_r)  r_done = 1;
            if (hs_rsp) done = 1;

            if (accepted) begin
                n_checks++;
                if (cmd_ready !== 1'(done)) begin
                    n_fail++; $display("FAIL %s cmd_ready: got %b want %b", tag, cmd_ready, done);
                end
                n_checks++;
                if (wr ? ({axi.arvalid, axi.rready} !== 2'b00)
                       : ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b000)) begin
                    n_fail++; $display("FAIL %s idle channel active: got %b want 0", tag,
                                       {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
                end
                if (wr) begin
                    exp_v = hs_cmd || (p_awvalid && !hs_aw);
                    n_checks++;
                    if (axi.awvalid !== exp_v || (p_awvalid && axi.awvalid && axi.awaddr !== p_awaddr)) begin
                        n_fail++; $display("FAIL %s awvalid/awaddr: got %b/%h want %b/%h", tag, axi.awvalid, axi.awaddr, exp_v, p_awaddr);
                    end
                    exp_v = hs_cmd || (p_wvalid && !hs_w);
                    n_checks++;
                    if (axi.wvalid !== exp_v || (p_wvalid && axi.wvalid && {axi.wdata, axi.wstrb} !== {p_wdata, p_wstrb})) begin
                        n_fail++; $display("FAIL %s wvalid/wdata: got %b/%h want %b/%h", tag, axi.wvalid, axi.wdata, exp_v, p_wdata);
                    end
                    exp_v = aw_done && w_done && !b_done;
                    n_checks++;
                    if (axi.bready !== exp_v) begin
                        n_fail++; $display("FAIL %s bready: got %b want %b", tag, axi.bready, exp_v);
                    end
                end else begin
                    exp_v = hs_cmd || (p_arvalid && !hs_ar);
                    n_checks++;
                    if (axi.arvalid !== exp_v || (p_arvalid && axi.arvalid && axi.araddr !== p_araddr)) begin
                        n_fail++; $display("FAIL %s arvalid/araddr: got %b/%h want %b/%h", tag, axi.arvalid, axi.araddr, exp_v, p_araddr);
                    end
                    exp_v = ar_done && !r_done;
                    n_checks++;
                    if (axi.rready !== exp_v) begin
                        n_fail++; $display("FAIL %s rready: got %b want %b", tag, axi.rready, exp_v);
                    end
                end
                exp_rv = (b_done || r_done) && !done && (cyc >= rdone_cyc + 1);
                n_checks++;
                if (rsp_valid !== exp_rv) begin
                    n_fail++; $display("FAIL %s rsp_valid: got %b want %b", tag, rsp_valid, exp_rv);
                end
                if (rsp_valid) begin
                    n_checks++;
                    if (rsp_rdata !== exp_data || rsp_resp !== code) begin
                        n_fail++; $display("FAIL %s rsp data/resp: got %h/%b want %h/%b", tag, rsp_rdata, rsp_resp, exp_data, code);
                    end
                    if (!rsp_seen && exp_lat > 0) begin
                        n_checks++;
                        if (cyc - acc_cyc != exp_lat) begin
                            n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, cyc - acc_cyc, exp_lat);
                        end
                    end
                    rsp_seen = 1;
                end
            end else begin
                n_checks++;
                if (cmd_ready !== 1'b1) begin
                    n_fail++; $display("FAIL %s cmd_ready idle: got %b want 1", tag, cmd_ready);
                end
            end

            if (abort && !done && axi.bready === 1'b1) begin
                #2 areset = 1'b1;
                #1;
                n_checks++;
                if ({axi.bready, axi.awvalid, axi.wvalid, rsp_valid, cmd_ready, axi.arvalid, axi.rready} !== 7'b0) begin
                    n_fail++; $display("FAIL %s async reset outputs: got %b want 0", tag,
                                       {axi.bready, axi.awvalid, axi.wvalid, rsp_valid, cmd_ready, axi.arvalid, axi.rready});
                end
                slave_idle();
                cmd_valid = 1'b0; rsp_ready = 1'b0;
                repeat (2) @(negedge ack);
                areset = 1'b0;
                @(negedge ack);
                n_checks++;
                if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || axi.bready !== 1'b0) begin
                    n_fail++; $display("FAIL %s after reset: got rdy=%b vld=%b bready=%b want 1/0/0", tag, cmd_ready, rsp_valid, axi.bready);
                end
                done = 1;
                break;
            end

            if (done) cmd_valid = 1'b0;
            else if (accepted) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end

            if (axi.awvalid && !aw_done) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else axi.awready = 1'($urandom_range(0, 1));
            if (axi.wvalid && !w_done) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
            else axi.wready = 1'($urandom_range(0, 1));
            if (axi.arvalid && !ar_done) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else axi.arready = 1'($urandom_range(0, 1));

            if (wr && accepted && !b_done && (early || (aw_done && w_done)) && resp_cnt >= resp_dly) begin
                axi.bvalid = 1'b1; axi.bresp = code;
            end else begin
                if (wr && accepted && !b_done && (early || (aw_done && w_done))) resp_cnt++;
                axi.bvalid = 1'b0; axi.bresp = 2'($urandom);
            end

            if (!wr && accepted && !r_done && (early || ar_done) && resp_cnt >= resp_dly) begin
                if (!axi.rvalid) r_idx = int'(axi.araddr[5:2]);
                axi.rvalid = 1'b1; axi.rdata = slv_mem[r_idx]; axi.rresp = code;
            end else begin
                if (!wr && accepted && !r_done && (early || ar_done)) resp_cnt++;
                axi.rvalid = 1'b0; axi.rdata = $urandom; axi.rresp = 2'($urandom);
            end

            if (rsp_valid && !done) begin rsp_ready = (rsp_cnt >= rsp_dly); rsp_cnt++; end
            else rsp_ready = 1'($urandom_range(0, 1));
        end

        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got no response after %0d cycles want response", tag, cyc);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        slave_idle();
        repeat (3) begin
            @(negedge ack);
            n_checks++;
            if (dut_outs() !== 141'b0) begin
                n_fail++; $display("FAIL reset outputs: got %h want 0", dut_outs());
            end
        end
        areset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset cmd_ready early: got %b want 0", cmd_ready);
        end
        @(negedge ack);
        n_checks++;
        if (cmd_ready !== 1'b1 || {rsp_valid, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 6'b0) begin
            n_fail++; $display("FAIL reset release: got rdy=%b valids=%b want 1/0", cmd_ready,
                               {rsp_valid, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
        end
    endtask

    task automatic test_single_read();
        ref_mem[0] = 32'h0000_00A5;
        slv_mem[0] = 32'h0000_00A5;
        run_txn("single_read", 1'b0, 32'h1, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 1'b0, 3, 1'b0);
    endtask

    task automatic test_write_min_latency();
        run_txn("write_fast", 1'b1, 32'h14, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 2'b01, 1'b0, 3, 1'b0);
    endtask

    task automatic test_skewed_write();
        run_txn("skewed_write", 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 0, 1, 2'b10, 1'b0, 0, 1'b0);
        run_txn("skewed_read", 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 1, 1, 0, 2'b00, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b01, 1'b0, 3, 1'b0);
    endtask

    task automatic test_stalled_slave();
        run_txn("stalled_slave", 1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 10, 0, 0, 2'b11, 1'b1, 0, 1'b0);
        run_txn("early_bvalid", 1'b1, 32'h34, 32'hCAFE_F00D, 4'h5, 2, 4, 0, 0, 0, 2'b00, 1'b1, 0, 1'b0);
    endtask

    task automatic test_mid_write_reset();
        run_txn("mid_write_reset", 1'b1, 32'h10, 32'h5555_AAAA, 4'hF, 0, 0, 0, 5, 0, 2'b00, 1'b0, 0, 1'b1);
        run_txn("read_after_reset", 1'b0, 32'h1, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_txn("random", 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 3), 2'($urandom),
                    1'($urandom_range(0, 1)), 0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        test_reset();
        test_single_read();
        test_write_min_latency();
        test_skewed_write();
        test_backpressure();
        test_stalled_slave();
        test_mid_write_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_aead128_axi_master.md
Name: ascon_aead128_axi_master

Overview:
- AXI4-Lite initiator: turns single-beat register commands into AXI4-Lite read or write transactions toward `ascon_aead128_ip`.
- Returns each transaction's data and response code on a valid/ready response port.
- Used as the bus driver in the system integration and in the IP regression benches, in place of hand-toggled channel signals.
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDRESS_WIDTH, 32, width of cmd_addr, awaddr, araddr
- DATA_WIDTH, 32, width of data buses; strobe width is DATA_WIDTH/8

Ports:
- ack  in  1  clock; every register updates on the rising edge
- areset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored for reads)
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  captured bresp or rresp
- awvalid  out  1  write-address valid
- awready  in  1  write-address ready
- awaddr  out  ADDRESS_WIDTH  write address
- wvalid  out  1  write-data valid
- wready  in  1  write-data ready
- wdata  out  DATA_WIDTH  write data
- wstrb  out  DATA_WIDTH/8  write strobes
- bvalid  in  1  write-response valid
- bready  out  1  write-response ready
- bresp  in  2  write response
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- araddr  out  ADDRESS_WIDTH  read address
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready
- rdata  in  DATA_WIDTH  read data
- rresp  in  2  read response

Behaviour:
- All outputs are registered. Reset (areset=1, asynchronous) drives every valid, every ready, cmd_ready and all data/address/strobe/response outputs to 0 and forces state IDLE.
- One cycle after areset deasserts, cmd_ready=1.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESPOND.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch addr/wdata/wstrb, drop cmd_ready, then:
  - write: go to WR_REQ with awvalid=1 and wvalid=1 from the next cycle;
  - read: go to RD_REQ with arvalid=1 from the next cycle.
- WR_REQ: AW and W complete independently.
  - awvalid clears on the cycle after awvalid && awready; wvalid clears likewise after wvalid && wready.
  - Each channel sets a done flag. Same-cycle handshakes on both channels are legal.
  - When both flags are set, go to WR_RESP with bready=1.
  - A valid is never withdrawn before its handshake. addr/data/strb stay stable while their valid is high.
- WR_RESP: on bvalid && bready, capture bresp, force rdata to 0, clear bready, go to RESPOND.
- RD_REQ: hold arvalid and araddr until arready. Then clear arvalid, set rready, go to RD_RESP.
- RD_RESP: on rvalid && rready, capture rdata and rresp, clear rready, go to RESPOND.
- bvalid or rvalid arriving before its address handshake completes is not accepted: ready stays low until the state is reached.
- RESPOND: rsp_valid=1. rsp_rdata and rsp_resp stay stable until rsp_ready.
  - On handshake, clear rsp_valid and return to IDLE; cmd_ready=1 on the following cycle.
  - Back-to-back commands therefore have a minimum 1-cycle gap.
- Minimum latency, with all slave readies high and the response returned on the first possible cycle:
  - command accept to rsp_valid: 3 cycles for a read, 3 cycles for a write.
- Response codes are passed through unmodified (OKAY/EXOKAY/SLVERR/DECERR); no retry.
- Reset mid-transaction aborts immediately and leaves no pending state. The bench must reset the slave together with the master.
- cmd_* inputs are ignored outside the IDLE handshake.

Test Plan:
- Reset: hold areset 3 cycles, release -> all outputs 0 during reset; cmd_ready=1 one cycle after release; no valid asserted.
- Single read: cmd_write=0, cmd_addr=32'h1; slave arready=1, then rvalid with rdata=32'h0000_00A5, rresp=0 -> araddr=32'h1 for one cycle; rsp_rdata=32'h0000_00A5, rsp_resp=0; rsp_valid held until rsp_ready.
- Skewed write: cmd_addr=32'h8, cmd_wdata=32'hDEAD_BEEF, cmd_wstrb=4'hF; slave gives wready 3 cycles before awready -> wvalid drops first, awvalid persists, bready rises only after both handshakes; bresp=2'b10 reported as rsp_resp=2'b10 with rsp_rdata=0.
- Backpressure: rsp_ready low 5 cycles after a read -> rsp_valid/rsp_rdata stable throughout, cmd_ready=0 until one cycle after the handshake.
- Stalled slave: arready low 10 cycles -> arvalid and araddr constant for all 10 cycles; early rvalid is not accepted (rready=0).
- Mid-write reset: assert areset while in WR_RESP -> bready, awvalid, wvalid and rsp_valid go to 0 asynchronously; after release a read to 32'h1 completes normally.
